sa_cache_sim_core: RTL and testbench

- Next-generation set-associative cache simulator core. It consumes a memory trace one address at a time over a valid/ready handshake and keeps tag/valid/dirty state per set.
- Adds a selectable replacement policy (LRU or FIFO), write-back dirty tracking, eviction and write-back statistics, a post-reset set-clearing sweep, and a stats-clear control.
- Sits between the trace source and the statistics/ILA observation logic on the FPGA.

---
 rtl/cache_sim_pkg.sv | 40 ++++
 rtl/sa_cache_sim_core_repl_select.sv | 73 +++++++
 rtl/sa_cache_sim_core.sv | 218 +++++++++++++++++++++
 tb/tb_sa_cache_sim_core.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_sim_pkg.sv
// rtl/cache_sim_pkg.sv - shared policy codes, FSM encoding and cache geometry helpers
package cache_sim_pkg;

    localparam int POLICY_LRU  = 0;
    localparam int POLICY_FIFO = 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int bits;
        int span;
        bits = 0;
        span = 1;
        while (span < value) begin
            span = span * 2;
            bits = bits + 1;
        end
        return bits;
    endfunction

    // Width of a way index / age field; a direct-mapped cache still needs one bit.
    function automatic int way_bits(input int way);
        return (way > 1) ? clog2(way) : 1;
    endfunction

    function automatic int calc_sets(input int cache_bytes, input int block_bytes, input int way);
        return cache_bytes / (block_bytes * way);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int cache_bytes,
                                      input int block_bytes, input int way);
        return addr_w - clog2(calc_sets(cache_bytes, block_bytes, way)) - clog2(block_bytes);
    endfunction

endpackage

// File: rtl/sa_cache_sim_core_repl_select.sv
// rtl/sa_cache_sim_core_repl_select.sv - victim choice and next LRU ages / FIFO pointer for one set
module repl_select
    import cache_sim_pkg::*;
#(
    parameter int WAY    = 4,
    parameter int POLICY = POLICY_LRU,
    parameter int WAY_W  = way_bits(WAY)
) (
    input  logic [WAY-1:0]       valid_vec,
    input  logic [WAY*WAY_W-1:0] ages,
    input  logic [WAY_W-1:0]     fifo_ptr,
    input  logic [WAY_W-1:0]     access_way,
    input  logic                 advance,
    output logic [WAY_W-1:0]     victim,
    output logic [WAY*WAY_W-1:0] next_ages,
    output logic [WAY_W-1:0]     next_ptr
);

    logic             found_invalid;
    logic [WAY_W-1:0] access_age;

    // Victim: fill an empty way first, otherwise the oldest line (LRU) or the FIFO head.
    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < WAY; w++) begin
            if (!valid_vec[w] && !found_invalid) begin
                victim        = WAY_W'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            if (POLICY == POLICY_FIFO) begin
                victim = fifo_ptr;
            end else begin
                for (int w = 0; w < WAY; w++) begin
                    if (ages[w*WAY_W +: WAY_W] == WAY_W'(WAY - 1)) begin
                        victim = WAY_W'(w);
                    end
                end
            end
        end
    end

    // Ages stay a permutation of 0..WAY-1: younger lines than the accessed one age by one.
    always_comb begin
        access_age = '0;
        for (int w = 0; w < WAY; w++) begin
            if (WAY_W'(w) == access_way) begin
                access_age = ages[w*WAY_W +: WAY_W];
            end
        end
        next_ages = ages;
        if (POLICY == POLICY_LRU) begin
            for (int w = 0; w < WAY; w++) begin
                if (WAY_W'(w) == access_way) begin
                    next_ages[w*WAY_W +: WAY_W] = '0;
                end else if (ages[w*WAY_W +: WAY_W] < access_age) begin
                    next_ages[w*WAY_W +: WAY_W] = ages[w*WAY_W +: WAY_W] + 1'b1;
                end
            end
        end
    end

    // The FIFO head only moves when a valid line is actually displaced.
    always_comb begin
        next_ptr = fifo_ptr;
        if (advance && (POLICY == POLICY_FIFO)) begin
            next_ptr = (fifo_ptr == WAY_W'(WAY - 1)) ? '0 : fifo_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sa_cache_sim_core.sv
// rtl/sa_cache_sim_core.sv - set-associative cache simulator: trace handshake, tag arrays, FSM, statistics
module sa_cache_sim_core
    import cache_sim_pkg::*;
#(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32768,
    parameter int ADDR_W          = 32,
    parameter int CNT_W           = 32,
    parameter int POLICY          = POLICY_LRU
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trace_valid,
    output logic              trace_ready,
    input  logic [ADDR_W-1:0] trace_addr,
    input  logic              trace_we,
    input  logic              clear_stats,
    output logic              resp_valid,
    output logic              last_hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  evict_count,
    output logic [CNT_W-1:0]  writeback_count,
    output logic              busy
);

    localparam int OFF_W = clog2(BLOCK_SIZE_BYTE);
    localparam int SETS  = calc_sets(CACHE_SIZE_BYTE, BLOCK_SIZE_BYTE, WAY);
    localparam int IDX_W = clog2(SETS);
    localparam int TAG_W = calc_tag_w(ADDR_W, CACHE_SIZE_BYTE, BLOCK_SIZE_BYTE, WAY);
    localparam int WAY_W = way_bits(WAY);

    // Per-set state; contents are meaningless until the INIT sweep has visited the set.
    logic [TAG_W-1:0]       tag_mem   [SETS][WAY];
    logic [WAY-1:0]         valid_mem [SETS];
    logic [WAY-1:0]         dirty_mem [SETS];
    logic [WAY*WAY_W-1:0]   age_mem   [SETS];
    logic [WAY_W-1:0]       fifo_mem  [SETS];

    state_t            state;
    logic [IDX_W-1:0]  init_ptr;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic              we_q;
    logic              hit_q;
    logic [WAY_W-1:0]  hit_way_q;
    logic [WAY_W-1:0]  victim_q;
    logic              vict_valid_q;
    logic              vict_dirty_q;

    logic [WAY-1:0]       set_valid;
    logic [WAY-1:0]       set_dirty;
    logic [WAY*WAY_W-1:0] set_ages;
    logic [WAY_W-1:0]     set_ptr;
    logic [WAY-1:0]       hit_vec;
    logic                 hit_any;
    logic [WAY_W-1:0]     hit_idx;
    logic [WAY_W-1:0]     victim;
    logic [WAY_W-1:0]     acc_way;
    logic                 advance;
    logic [WAY*WAY_W-1:0] next_ages;
    logic [WAY_W-1:0]     next_ptr;
    logic [WAY*WAY_W-1:0] init_ages;
    logic                 unused_offset;

    // Byte offset within the line never affects hit/miss behaviour.
    assign unused_offset = ^trace_addr[OFF_W-1:0];

    // Read the latched set and compare the tag against every valid way.
    always_comb begin
        set_valid = valid_mem[idx_q];
        set_dirty = dirty_mem[idx_q];
        set_ages  = age_mem[idx_q];
        set_ptr   = fifo_mem[idx_q];
        hit_any   = 1'b0;
        hit_idx   = '0;
        for (int w = 0; w < WAY; w++) begin
            hit_vec[w] = set_valid[w] && (tag_mem[idx_q][w] == tag_q);
            if (hit_vec[w] && !hit_any) begin
                hit_any = 1'b1;
                hit_idx = WAY_W'(w);
            end
        end
    end

    // Reset value of the LRU ages: way w starts with age w.
    always_comb begin
        init_ages = '0;
        for (int w = 0; w < WAY; w++) begin
            init_ages[w*WAY_W +: WAY_W] = WAY_W'(w);
        end
    end

    assign acc_way = hit_q ? hit_way_q : victim_q;
    assign advance = !hit_q && vict_valid_q;

    repl_select #(
        .WAY    (WAY),
        .POLICY (POLICY),
        .WAY_W  (WAY_W)
    ) u_repl_select (
        .valid_vec  (set_valid),
        .ages       (set_ages),
        .fifo_ptr   (set_ptr),
        .access_way (acc_way),
        .advance    (advance),
        .victim     (victim),
        .next_ages  (next_ages),
        .next_ptr   (next_ptr)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    // Array writes: INIT clears one set per cycle, UPDATE commits the access; reset blocks both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                valid_mem[init_ptr] <= '0;
                dirty_mem[init_ptr] <= '0;
                age_mem[init_ptr]   <= init_ages;
                fifo_mem[init_ptr]  <= '0;
            end else if (state == ST_UPDATE) begin
                tag_mem[idx_q][acc_way]   <= tag_q;
                valid_mem[idx_q][acc_way] <= 1'b1;
                dirty_mem[idx_q][acc_way] <= hit_q ? (set_dirty[acc_way] | we_q) : we_q;
                age_mem[idx_q]            <= next_ages;
                fifo_mem[idx_q]           <= next_ptr;
            end
        end
    end

    // Control FSM with registered handshake, response and statistics outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_INIT;
            init_ptr        <= '0;
            trace_ready     <= 1'b0;
            busy            <= 1'b1;
            resp_valid      <= 1'b0;
            last_hit        <= 1'b0;
            hit_count       <= '0;
            miss_count      <= '0;
            evict_count     <= '0;
            writeback_count <= '0;
            tag_q           <= '0;
            idx_q           <= '0;
            we_q            <= 1'b0;
            hit_q           <= 1'b0;
            hit_way_q       <= '0;
            victim_q        <= '0;
            vict_valid_q    <= 1'b0;
            vict_dirty_q    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (init_ptr == IDX_W'(SETS - 1)) begin
                        state       <= ST_IDLE;
                        init_ptr    <= '0;
                        trace_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        init_ptr <= init_ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (trace_valid && trace_ready) begin
                        tag_q       <= trace_addr[ADDR_W-1 -: TAG_W];
                        idx_q       <= trace_addr[OFF_W +: IDX_W];
                        we_q        <= trace_we;
                        state       <= ST_LOOKUP;
                        trace_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    hit_q        <= hit_any;
                    hit_way_q    <= hit_idx;
                    victim_q     <= victim;
                    vict_valid_q <= set_valid[victim];
                    vict_dirty_q <= set_dirty[victim];
                    state        <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (hit_q) begin
                        hit_count <= sat_inc(hit_count);
                    end else begin
                        miss_count <= sat_inc(miss_count);
                        if (vict_valid_q) begin
                            evict_count <= sat_inc(evict_count);
                            if (vict_dirty_q) begin
                                writeback_count <= sat_inc(writeback_count);
                            end
                        end
                    end
                    resp_valid  <= 1'b1;
                    last_hit    <= hit_q;
                    state       <= ST_IDLE;
                    trace_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
            if (clear_stats) begin
                hit_count       <= '0;
                miss_count      <= '0;
                evict_count     <= '0;
                writeback_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sa_cache_sim_core.sv
// tb/tb_sa_cache_sim_core.sv - directed checks of the LRU and FIFO cache cores driven in lockstep
module tb_sa_cache_sim_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_valid;
    logic [31:0] trace_addr;
    logic        trace_we;
    logic        clear_stats;

    logic [1:0]        rdy;
    logic [1:0]        rv;
    logic [1:0]        lh;
    logic [1:0]        bsy;
    logic [1:0][31:0]  hc;
    logic [1:0][31:0]  mc;
    logic [1:0][31:0]  ec;
    logic [1:0][31:0]  wc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sa_cache_sim_core #(.POLICY(0)) u_lru (
        .clk             (clk),
        .rst             (rst),
        .trace_valid     (trace_valid),
        .trace_ready     (rdy[0]),
        .trace_addr      (trace_addr),
        .trace_we        (trace_we),
        .clear_stats     (clear_stats),
        .resp_valid      (rv[0]),
        .last_hit        (lh[0]),
        .hit_count       (hc[0]),
        .miss_count      (mc[0]),
        .evict_count     (ec[0]),
        .writeback_count (wc[0]),
        .busy            (bsy[0])
    );

    sa_cache_sim_core #(.POLICY(1)) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .trace_valid     (trace_valid),
        .trace_ready     (rdy[1]),
        .trace_addr      (trace_addr),
        .trace_we        (trace_we),
        .clear_stats     (clear_stats),
        .resp_valid      (rv[1]),
        .last_hit        (lh[1]),
        .hit_count       (hc[1]),
        .miss_count      (mc[1]),
        .evict_count     (ec[1]),
        .writeback_count (wc[1]),
        .busy            (bsy[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_counts(input string tag, input int h, input int m, input int e, input int w);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s_hits_%0d", tag, i), hc[i], h);
            check_eq($sformatf("%s_misses_%0d", tag, i), mc[i], m);
            check_eq($sformatf("%s_evicts_%0d", tag, i), ec[i], e);
            check_eq($sformatf("%s_wbacks_%0d", tag, i), wc[i], w);
        end
    endtask

    // Count edges after reset release until both cores are ready; no response may appear meanwhile.
    task automatic wait_init(input string tag);
        int n = 0;
        logic saw_resp = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (rv != 2'b00) saw_resp = 1'b1;
        end while (rdy[0] !== 1'b1 && n < 600);
        check_eq({tag, "_init_cycles"}, n, 512);
        check_eq({tag, "_ready"}, rdy, 2'b11);
        check_eq({tag, "_busy"}, bsy, 2'b00);
        check_eq({tag, "_no_resp"}, saw_resp, 1'b0);
    endtask

    task automatic reset_and_init(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_rst_ready"}, rdy, 2'b00);
        check_eq({tag, "_rst_busy"}, bsy, 2'b11);
        check_eq({tag, "_rst_resp"}, rv, 2'b00);
        check_eq({tag, "_rst_last_hit"}, lh, 2'b00);
        check_counts({tag, "_rst"}, 0, 0, 0, 0);
        rst = 1'b0;
        wait_init(tag);
    endtask

    // One access; exp_hit[0] is the LRU result, exp_hit[1] the FIFO result.
    task automatic access(input logic [31:0] addr, input logic we, input logic clr,
                          input logic [1:0] exp_hit);
        int n = 0;
        @(negedge clk);
        while (rdy[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("accept_wait_%0h", addr), n < 50, 1'b1);
        trace_valid = 1'b1;
        trace_addr  = addr;
        trace_we    = we;
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        trace_addr  = 32'hFFFF_FFF0;
        trace_we    = ~we;
        check_eq($sformatf("taken_%0h", addr), rdy, 2'b00);
        @(negedge clk);
        check_eq($sformatf("resp_lookup_%0h", addr), rv, 2'b00);
        @(negedge clk);
        check_eq($sformatf("resp_update_%0h", addr), rv, 2'b00);
        if (clr) clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check_eq($sformatf("resp_valid_%0h", addr), rv, 2'b11);
        check_eq($sformatf("last_hit_%0h", addr), lh, exp_hit);
    endtask

    logic [31:0] seq_addr [8] = '{32'h0000, 32'h2000, 32'h4000, 32'h6000,
                                  32'h0000, 32'h8000, 32'h2000, 32'h0000};
    logic [1:0]  seq_hit  [8] = '{2'b00, 2'b00, 2'b00, 2'b00,
                                  2'b11, 2'b00, 2'b10, 2'b01};

    initial begin
        rst         = 1'b1;
        trace_valid = 1'b0;
        trace_addr  = '0;
        trace_we    = 1'b0;
        clear_stats = 1'b0;

        reset_and_init("por");

        access(32'h1000, 1'b0, 1'b0, 2'b00);
        check_counts("cold", 0, 1, 0, 0);
        access(32'h100C, 1'b0, 1'b0, 2'b11);
        check_counts("same_line", 1, 1, 0, 0);

        reset_and_init("repl");
        for (int i = 0; i < 8; i++) begin
            access(seq_addr[i], 1'b0, 1'b0, seq_hit[i]);
        end
        check_counts("repl", 2, 6, 2, 0);

        reset_and_init("wb");
        access(32'h0000, 1'b1, 1'b0, 2'b00);
        access(32'h2000, 1'b0, 1'b0, 2'b00);
        access(32'h4000, 1'b0, 1'b0, 2'b00);
        access(32'h6000, 1'b0, 1'b0, 2'b00);
        access(32'h8000, 1'b0, 1'b0, 2'b00);
        check_counts("wb", 0, 5, 1, 1);

        access(32'hA000, 1'b0, 1'b1, 2'b00);
        check_counts("clear", 0, 0, 0, 0);

        access(32'h1000, 1'b0, 1'b0, 2'b00);
        check_counts("post_clear", 0, 1, 0, 0);

        @(negedge clk);
        trace_valid = 1'b1;
        trace_addr  = 32'h3000;
        trace_we    = 1'b1;
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_resp_a", rv, 2'b00);
        @(posedge clk);
        #1;
        check_eq("mid_rst_resp_b", rv, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        check_counts("mid_rst", 0, 0, 0, 0);
        wait_init("mid_rst");
        check_eq("mid_rst_last_hit", lh, 2'b00);
        check_counts("after_mid_rst", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
